// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch: one outstanding fetch, PC/word FIFO to decode,
// redirect flush with stale-response discard.
module inst_prefetch_queue #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_start,
  input  logic        inst_ready,
  output logic [31:0] i_addr,
  input  logic [31:0] inst,
  input  logic        inst_valid,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  input  logic        jump_valid,
  input  logic [31:0] jump_addr,
  input  logic        halt
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic [31:0]   pc_q   [QUEUE_DEPTH];
  logic [31:0]   inst_q [QUEUE_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic accept;
  logic push;
  logic pop;

  assign inst_start = !reset && state == IDLE && !halt
                    && !jump_valid && count < DEPTH_C;
  assign i_addr     = fetch_pc;
  assign accept     = inst_start && inst_ready;
  assign push       = state == WAIT && inst_valid && !jump_valid;
  assign pop        = id_valid && id_ready && !jump_valid;

  assign id_valid = count != '0;
  assign id_pc    = id_valid ? pc_q[rd_ptr] : 32'h0;
  assign id_inst  = id_valid ? inst_q[rd_ptr] : 32'hffffffff;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = WAIT;
      end
      WAIT: begin
        if (inst_valid)      state_nxt = IDLE;
        else if (jump_valid) state_nxt = DISCARD;
      end
      DISCARD: begin
        if (inst_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) req_pc <= fetch_pc;
      if (jump_valid) begin
        fetch_pc <= {jump_addr[31:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (accept) fetch_pc <= fetch_pc + 32'd4;
        if (push)   wr_ptr   <= wr_ptr + P_ONE;
        if (pop)    rd_ptr   <= rd_ptr + P_ONE;
        if (push && !pop)      count <= count + C_ONE;
        else if (pop && !push) count <= count - C_ONE;
      end
    end
  end

  // Storage needs no reset: empty entries are masked at the head.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]   <= req_pc;
      inst_q[wr_ptr] <= inst;
    end
  end

endmodule
